lfsr_sched: RTL and testbench

Round-robin scheduler that shares one 8-bit LFSR random source among several game-logic requesters (e.g. produce spawners, lane pickers). It owns the LFSR state register, loads seeds, advances the register a fixed number of steps per request for decorrelation, and returns one random byte to exactly one requester per grant.

---
 rtl/lfsr_sched.sv | 127 ++++++++++++
 tb/tb_lfsr_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_sched.sv
// lfsr_sched: round-robin scheduler sharing one 8-bit LFSR among N_REQ requesters.
// Optional macro LFSR_SCHED_ZERO_GUARD_EN replaces any all-zero write of the LFSR with 8'h01.
module lfsr_sched #(
   parameter int N_REQ = 4,
   parameter int STEPS = 3
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [7:0]       seed_in,
   input  logic             seed_load,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [7:0]       rnd_out,
   output logic             rnd_valid,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, SEED, STEP, GRANT} state_t;

   state_t     state;
   state_t     state_nx;
   logic [7:0] s;
   logic [7:0] s_wr;
   logic [7:0] req_ext;
   logic [2:0] ptr;
   logic [2:0] winner;
   logic [2:0] win_sel;
   logic [3:0] idx;
   logic [3:0] cnt;
   logic       win_found;
   logic       last_step;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      logic f;
      f = v[7] ^ v[5] ^ v[4] ^ v[3];
      return {f, v[5:0], f};
   endfunction

   assign req_ext   = 8'(req);
   assign last_step = (cnt == 4'(STEPS - 1));

   // Round-robin search: first set request at or after ptr, wrapping modulo N_REQ.
   always_comb begin
      win_found = 1'b0;
      win_sel   = ptr;
      idx       = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = {1'b0, ptr} + 4'(i);
         if (idx >= 4'(N_REQ)) begin
            idx = idx - 4'(N_REQ);
         end
         if (!win_found && req_ext[idx[2:0]]) begin
            win_found = 1'b1;
            win_sel   = idx[2:0];
         end
      end
   end

   always_comb begin
      s_wr = (state == SEED) ? seed_in : lfsr_next(s);
`ifdef LFSR_SCHED_ZERO_GUARD_EN
      if (s_wr == 8'h00) begin
         s_wr = 8'h01;
      end
`endif
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (seed_load) begin
               state_nx = SEED;
            end else if (win_found) begin
               state_nx = STEP;
            end
         end
         SEED:    state_nx = IDLE;
         STEP:    if (last_step) state_nx = GRANT;
         GRANT:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // rnd_out is loaded on the final step so it already holds the new value during GRANT.
   always_ff @(posedge clk) begin
      if (clr) begin
         state   <= IDLE;
         s       <= 8'h01;
         ptr     <= 3'd0;
         cnt     <= 4'd0;
         winner  <= 3'd0;
         rnd_out <= 8'h00;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (!seed_load && win_found) begin
                  winner <= win_sel;
                  cnt    <= 4'd0;
               end
            end
            SEED: s <= s_wr;
            STEP: begin
               s   <= s_wr;
               cnt <= cnt + 4'd1;
               if (last_step) begin
                  rnd_out <= s_wr;
               end
            end
            GRANT: ptr <= (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      gnt       = '0;
      rnd_valid = 1'b0;
      busy      = (state != IDLE);
      if (state == GRANT) begin
         gnt       = N_REQ'(8'h01 << winner);
         rnd_valid = 1'b1;
      end
   end

endmodule

// File: tb/tb_lfsr_sched.sv
// tb_lfsr_sched: self-checking bench for lfsr_sched (N_REQ=4, STEPS=3) using fixed vectors,
// directed corner sequences and randomized traffic against a transaction-level model.
module tb_lfsr_sched;

   localparam int N     = 4;
   localparam int STEPS = 3;

   logic         clk = 1'b0;
   logic         clr;
   logic [7:0]   seed_in;
   logic         seed_load;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic [7:0]   rnd_out;
   logic         rnd_valid;
   logic         busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] ms;
   int         mp;

   typedef struct {
      bit         rst;
      logic [3:0] rq;
      logic [3:0] g;
      logic [7:0] r;
      int         cyc;
   } vec_t;

   vec_t tbl[7];

   lfsr_sched #(.N_REQ(N), .STEPS(STEPS)) dut (
      .clk       (clk),
      .clr       (clr),
      .seed_in   (seed_in),
      .seed_load (seed_load),
      .req       (req),
      .gnt       (gnt),
      .rnd_out   (rnd_out),
      .rnd_valid (rnd_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] m_guard(input logic [7:0] v);
`ifdef LFSR_SCHED_ZERO_GUARD_EN
      if (v == 8'h00) return 8'h01;
`endif
      return v;
   endfunction

   // Feedback is the parity of the tapped bits 7,5,4,3; bit 6 falls off the top.
   function automatic logic [7:0] m_step(input logic [7:0] v);
      int x;
      int fb;
      int y;
      x  = int'(v);
      fb = $countones(v & 8'hB8) % 2;
      y  = ((x * 2) % 128) + fb + (fb * 128);
      return m_guard(8'(y));
   endfunction

   task automatic m_grant(input logic [3:0] mask, output int w, output logic [7:0] e);
      w = -1;
      for (int k = 0; k < N; k++) begin
         if (w < 0 && ((mask >> ((mp + k) % N)) & 4'd1) != 4'd0) begin
            w = (mp + k) % N;
         end
      end
      mp = (w + 1) % N;
      for (int k = 0; k < STEPS; k++) begin
         ms = m_step(ms);
      end
      e = ms;
   endtask

   task automatic do_reset();
      req       = '0;
      seed_load = 1'b0;
      seed_in   = 8'h00;
      clr       = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      clr = 1'b0;
      ms  = 8'h01;
      mp  = 0;
   endtask

   task automatic wait_gnt(input bit drop, output int cyc);
      logic [7:0] r0;
      bit         moved;
      r0    = rnd_out;
      moved = 1'b0;
      cyc   = -1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (drop) req = '0;
         if (gnt != '0) begin
            cyc = c;
            break;
         end
         if (rnd_out != r0 || rnd_valid) moved = 1'b1;
      end
      checkOutput("quiet_before_grant", 32'(moved), 32'd0);
   endtask

   task automatic applyStimulus(input logic [3:0] mask, input bit drop);
      int         w;
      int         cyc;
      logic [7:0] e;
      m_grant(mask, w, e);
      req = mask;
      wait_gnt(drop, cyc);
      req = '0;
      checkOutput("grant_latency", 32'(cyc), 32'(STEPS + 1));
      checkOutput("grant_onehot", 32'(gnt), 32'd1 << w);
      checkOutput("grant_rnd", 32'(rnd_out), 32'(e));
      checkOutput("grant_valid", 32'(rnd_valid), 32'd1);
      @(posedge clk); #1;
      checkOutput("post_grant_gnt", 32'(gnt), 32'd0);
      checkOutput("post_grant_hold", 32'(rnd_out), 32'(e));
      checkOutput("post_grant_busy", 32'(busy), 32'd0);
   endtask

   task automatic do_seed(input logic [7:0] v);
      seed_in   = v;
      seed_load = 1'b1;
      @(posedge clk); #1;
      seed_load = 1'b0;
      checkOutput("seed_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      checkOutput("seed_done", 32'(busy), 32'd0);
      ms = m_guard(v);
   endtask

   initial begin
      int         cyc;
      int         w;
      logic [7:0] e;
      bit         saw;

      clr       = 1'b1;
      seed_load = 1'b0;
      seed_in   = 8'h00;
      req       = '0;

      tbl[0] = '{1'b1, 4'b0001, 4'b0001, 8'h08, 4};
      tbl[1] = '{1'b0, 4'b0001, 4'b0001, 8'hC5, 5};
      tbl[2] = '{1'b1, 4'b1111, 4'b0001, 8'h08, 4};
      tbl[3] = '{1'b0, 4'b1111, 4'b0010, 8'hC5, 5};
      tbl[4] = '{1'b0, 4'b1111, 4'b0100, 8'hAD, 5};
      tbl[5] = '{1'b0, 4'b1111, 4'b1000, 8'hEF, 5};
      tbl[6] = '{1'b0, 4'b1111, 4'b0001, 8'h7E, 5};

      do_reset();
      checkOutput("reset_gnt", 32'(gnt), 32'd0);
      checkOutput("reset_valid", 32'(rnd_valid), 32'd0);
      checkOutput("reset_rnd", 32'(rnd_out), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);

      // Requests held continuously: first grant after STEPS+1, then every STEPS+2.
      for (int i = 0; i < 7; i++) begin
         if (tbl[i].rst) do_reset();
         req = tbl[i].rq;
         wait_gnt(1'b0, cyc);
         checkOutput($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].g));
         checkOutput($sformatf("tbl%0d_rnd", i), 32'(rnd_out), 32'(tbl[i].r));
         checkOutput($sformatf("tbl%0d_cyc", i), 32'(cyc), 32'(tbl[i].cyc));
      end

      // Seed and request in the same IDLE cycle: seed goes first.
      do_reset();
      seed_in   = 8'h91;
      seed_load = 1'b1;
      req       = 4'b0100;
      @(posedge clk); #1;
      seed_load = 1'b0;
      checkOutput("collide_busy", 32'(busy), 32'd1);
      checkOutput("collide_no_gnt", 32'(gnt), 32'd0);
      ms = m_guard(8'h91);
      m_grant(4'b0100, w, e);
      wait_gnt(1'b0, cyc);
      req = '0;
      checkOutput("collide_cyc", 32'(cyc), 32'(STEPS + 2));
      checkOutput("collide_gnt", 32'(gnt), 32'b0100);
      checkOutput("collide_rnd", 32'(rnd_out), 32'(e));
      @(posedge clk); #1;

      // Zero state: seed 0x40 steps into 0x00; seed 0x00 directly.
      do_reset();
      do_seed(8'h40);
      applyStimulus(4'b0001, 1'b0);
      applyStimulus(4'b0010, 1'b0);
      do_seed(8'h00);
      applyStimulus(4'b0001, 1'b0);

      // Reset during the second STEP cycle cancels the grant.
      do_reset();
      saw = 1'b0;
      req = 4'b0001;
      @(posedge clk); #1;
      saw |= (gnt != '0);
      @(posedge clk); #1;
      saw |= (gnt != '0);
      checkOutput("midstep_busy", 32'(busy), 32'd1);
      clr = 1'b1;
      req = '0;
      @(posedge clk); #1;
      clr = 1'b0;
      checkOutput("midstep_gnt", 32'(gnt), 32'd0);
      checkOutput("midstep_valid", 32'(rnd_valid), 32'd0);
      checkOutput("midstep_rnd", 32'(rnd_out), 32'd0);
      checkOutput("midstep_busy0", 32'(busy), 32'd0);
      repeat (6) begin
         @(posedge clk); #1;
         saw |= (gnt != '0) || busy;
      end
      checkOutput("midstep_no_gnt", 32'(saw), 32'd0);
      ms = 8'h01;
      mp = 0;
      applyStimulus(4'b0001, 1'b0);

      // seed_load pulsed while busy is ignored.
      do_reset();
      req = 4'b0001;
      @(posedge clk); #1;
      req       = '0;
      seed_in   = 8'h55;
      seed_load = 1'b1;
      @(posedge clk); #1;
      seed_load = 1'b0;
      m_grant(4'b0001, w, e);
      wait_gnt(1'b0, cyc);
      checkOutput("busyseed_cyc", 32'(cyc), 32'(STEPS - 1));
      checkOutput("busyseed_gnt", 32'(gnt), 32'b0001);
      checkOutput("busyseed_rnd", 32'(rnd_out), 32'h08);
      @(posedge clk); #1;
      applyStimulus(4'b0001, 1'b0);

      do_reset();
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0:       do_seed(8'h00);
               1:       do_seed(8'h40);
               default: do_seed(8'($urandom));
            endcase
         end else begin
            applyStimulus(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
